// File: rtl/axa_mult_arbiter_if.sv
// ---------------------------------------------------------------------------
// axa_mult_arbiter_if
// Purpose : bundles the two requester ports, the shared result bus and the
//           external 2x2 multiplier control/data into one interface.
// Modports: slave  - arbiter view (requests/operands/multiplier status in,
//                    grants/done/result/multiplier control out)
//           master - environment view (requesters + multiplier)
// Option  : AXA_ARB_TIMEOUT_EN adds output_Error (watchdog abort pulse).
// ---------------------------------------------------------------------------
interface axa_mult_arbiter_if;
  logic        input_Req0, input_Req1, input_Ack0, input_Ack1;
  logic [31:0] input_R0_A11, input_R0_A12, input_R0_A21, input_R0_A22;
  logic [31:0] input_R0_B11, input_R0_B12, input_R0_B21, input_R0_B22;
  logic [31:0] input_R1_A11, input_R1_A12, input_R1_A21, input_R1_A22;
  logic [31:0] input_R1_B11, input_R1_B12, input_R1_B21, input_R1_B22;
  logic        input_M_AB_Ack, input_M_Stable;
  logic [31:0] input_M_C11, input_M_C12, input_M_C21, input_M_C22;
  logic        output_Grant0, output_Grant1, output_Done0, output_Done1;
  logic [31:0] output_C11, output_C12, output_C21, output_C22;
  logic        output_Busy, output_M_Start, output_M_Stable, output_M_C_Ack;
  logic [31:0] output_M_A11, output_M_A12, output_M_A21, output_M_A22;
  logic [31:0] output_M_B11, output_M_B12, output_M_B21, output_M_B22;
`ifdef AXA_ARB_TIMEOUT_EN
  logic        output_Error;
`endif

  modport slave (
    input  input_Req0, input_Req1, input_Ack0, input_Ack1,
    input  input_R0_A11, input_R0_A12, input_R0_A21, input_R0_A22,
    input  input_R0_B11, input_R0_B12, input_R0_B21, input_R0_B22,
    input  input_R1_A11, input_R1_A12, input_R1_A21, input_R1_A22,
    input  input_R1_B11, input_R1_B12, input_R1_B21, input_R1_B22,
    input  input_M_AB_Ack, input_M_Stable,
    input  input_M_C11, input_M_C12, input_M_C21, input_M_C22,
`ifdef AXA_ARB_TIMEOUT_EN
    output output_Error,
`endif
    output output_Grant0, output_Grant1, output_Done0, output_Done1,
    output output_C11, output_C12, output_C21, output_C22,
    output output_Busy, output_M_Start, output_M_Stable, output_M_C_Ack,
    output output_M_A11, output_M_A12, output_M_A21, output_M_A22,
    output output_M_B11, output_M_B12, output_M_B21, output_M_B22
  );

  modport master (
    output input_Req0, input_Req1, input_Ack0, input_Ack1,
    output input_R0_A11, input_R0_A12, input_R0_A21, input_R0_A22,
    output input_R0_B11, input_R0_B12, input_R0_B21, input_R0_B22,
    output input_R1_A11, input_R1_A12, input_R1_A21, input_R1_A22,
    output input_R1_B11, input_R1_B12, input_R1_B21, input_R1_B22,
    output input_M_AB_Ack, input_M_Stable,
    output input_M_C11, input_M_C12, input_M_C21, input_M_C22,
`ifdef AXA_ARB_TIMEOUT_EN
    input  output_Error,
`endif
    input  output_Grant0, output_Grant1, output_Done0, output_Done1,
    input  output_C11, output_C12, output_C21, output_C22,
    input  output_Busy, output_M_Start, output_M_Stable, output_M_C_Ack,
    input  output_M_A11, output_M_A12, output_M_A21, output_M_A22,
    input  output_M_B11, output_M_B12, output_M_B21, output_M_B22
  );
endinterface

// File: rtl/axa_mult_arbiter.sv
// ---------------------------------------------------------------------------
// axa_mult_arbiter
// Purpose : round-robin arbiter giving two requesters shared access to one
//           external 2x2 single-precision matrix multiplier. Operands and
//           results are passed through unchanged (no arithmetic here).
// Ports   : input_Clk   - clock, rising edge
//           input_Reset - asynchronous, active-low reset
//           bus         - axa_mult_arbiter_if.slave (requests, operands,
//                         grants, done, result bus, multiplier handshake)
// Option  : AXA_ARB_TIMEOUT_EN adds an 8-bit watchdog that aborts a stuck
//           multiplier operation after 256 cycles and pulses output_Error.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for a request; operands captured on the granting edge
// ISSUE     | M_Start/M_Stable high until the multiplier acks the operands
// WAIT_RES  | M_Stable high, waiting for the multiplier result to be stable
// DELIVER   | Done of the granted requester high, result held on output_C*
// ---------------------------------------------------------------------------
module axa_mult_arbiter (
  input  logic             input_Clk,
  input  logic             input_Reset,
  axa_mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RES, S_DELIVER} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last;      // requester served last (reset: 1)
  logic             r_gnt_id;    // requester owning the current transaction
  logic             r_grant0, r_grant1, r_c_ack;
  logic [3:0][31:0] r_m_a, r_m_b, r_c;

  logic [3:0][31:0] w_a0, w_b0, w_a1, w_b1, w_mc;
  logic             w_any, w_sel, w_ack_sel;
  logic             w_issue, w_latch_c, w_release;

  // Index order 0..3 = 11, 12, 21, 22
  assign w_a0 = {bus.input_R0_A22, bus.input_R0_A21, bus.input_R0_A12, bus.input_R0_A11};
  assign w_b0 = {bus.input_R0_B22, bus.input_R0_B21, bus.input_R0_B12, bus.input_R0_B11};
  assign w_a1 = {bus.input_R1_A22, bus.input_R1_A21, bus.input_R1_A12, bus.input_R1_A11};
  assign w_b1 = {bus.input_R1_B22, bus.input_R1_B21, bus.input_R1_B12, bus.input_R1_B11};
  assign w_mc = {bus.input_M_C22, bus.input_M_C21, bus.input_M_C12, bus.input_M_C11};

  // Both requesting: the one not served last wins; otherwise the only one.
  assign w_any     = bus.input_Req0 | bus.input_Req1;
  assign w_sel     = (bus.input_Req0 & bus.input_Req1) ? ~r_last : bus.input_Req1;
  assign w_ack_sel = r_gnt_id ? bus.input_Ack1 : bus.input_Ack0;

`ifdef AXA_ARB_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       r_error;
  logic       w_timeout;

  assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT_RES)) && (r_wdog == 8'd255);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_latch_c   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
          w_issue     = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.input_M_AB_Ack) w_state_nxt = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (bus.input_M_Stable) begin
          w_state_nxt = S_DELIVER;
          w_latch_c   = 1'b1;
        end
      end
      S_DELIVER: begin
        // The multiplier must have released M_Stable before the next issue.
        if (w_ack_sel && !bus.input_M_Stable) begin
          w_state_nxt = S_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef AXA_ARB_TIMEOUT_EN
    // Abort wins over a result arriving in the same cycle: no Done is given.
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
      w_latch_c   = 1'b0;
      w_release   = 1'b1;
    end
`endif
  end

  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_gnt_id <= 1'b0;
      r_grant0 <= 1'b0;
      r_grant1 <= 1'b0;
      r_c_ack  <= 1'b0;
      r_m_a    <= '0;
      r_m_b    <= '0;
      r_c      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant0 <= w_issue & ~w_sel;
      r_grant1 <= w_issue & w_sel;
      r_c_ack  <= w_latch_c;
      if (w_issue) begin
        r_gnt_id <= w_sel;
        r_m_a    <= w_sel ? w_a1 : w_a0;
        r_m_b    <= w_sel ? w_b1 : w_b0;
      end
      if (w_latch_c) r_c    <= w_mc;
      if (w_release) r_last <= r_gnt_id;
    end
  end

`ifdef AXA_ARB_TIMEOUT_EN
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      r_wdog  <= 8'd0;
      r_error <= 1'b0;
    end else begin
      r_error <= w_timeout;
      if (w_issue) r_wdog <= 8'd0;
      else if ((r_state == S_ISSUE) || (r_state == S_WAIT_RES)) r_wdog <= r_wdog + 8'd1;
    end
  end

  assign bus.output_Error = r_error;
`endif

  assign bus.output_Busy     = (r_state != S_IDLE);
  assign bus.output_M_Start  = (r_state == S_ISSUE);
  assign bus.output_M_Stable = (r_state == S_ISSUE) || (r_state == S_WAIT_RES);
  assign bus.output_M_C_Ack  = r_c_ack;
  assign bus.output_Grant0   = r_grant0;
  assign bus.output_Grant1   = r_grant1;
  assign bus.output_Done0    = (r_state == S_DELIVER) && !r_gnt_id;
  assign bus.output_Done1    = (r_state == S_DELIVER) && r_gnt_id;

  assign bus.output_M_A11 = r_m_a[0];
  assign bus.output_M_A12 = r_m_a[1];
  assign bus.output_M_A21 = r_m_a[2];
  assign bus.output_M_A22 = r_m_a[3];
  assign bus.output_M_B11 = r_m_b[0];
  assign bus.output_M_B12 = r_m_b[1];
  assign bus.output_M_B21 = r_m_b[2];
  assign bus.output_M_B22 = r_m_b[3];
  assign bus.output_C11   = r_c[0];
  assign bus.output_C12   = r_c[1];
  assign bus.output_C21   = r_c[2];
  assign bus.output_C22   = r_c[3];

endmodule

// File: tb/tb_axa_mult_arbiter.sv
module tb_axa_mult_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axa_mult_arbiter_if bus ();
  axa_mult_arbiter dut (.input_Clk(clk), .input_Reset(rst_n), .bus(bus));

  logic        rq0, rq1, ak0, ak1, abk, mst;
  logic [31:0] r0a[4], r0b[4], r1a[4], r1b[4], mc[4];

  assign bus.input_Req0 = rq0;  assign bus.input_Req1 = rq1;
  assign bus.input_Ack0 = ak0;  assign bus.input_Ack1 = ak1;
  assign bus.input_M_AB_Ack = abk; assign bus.input_M_Stable = mst;
  assign bus.input_R0_A11 = r0a[0]; assign bus.input_R0_A12 = r0a[1];
  assign bus.input_R0_A21 = r0a[2]; assign bus.input_R0_A22 = r0a[3];
  assign bus.input_R0_B11 = r0b[0]; assign bus.input_R0_B12 = r0b[1];
  assign bus.input_R0_B21 = r0b[2]; assign bus.input_R0_B22 = r0b[3];
  assign bus.input_R1_A11 = r1a[0]; assign bus.input_R1_A12 = r1a[1];
  assign bus.input_R1_A21 = r1a[2]; assign bus.input_R1_A22 = r1a[3];
  assign bus.input_R1_B11 = r1b[0]; assign bus.input_R1_B12 = r1b[1];
  assign bus.input_R1_B21 = r1b[2]; assign bus.input_R1_B22 = r1b[3];
  assign bus.input_M_C11 = mc[0]; assign bus.input_M_C12 = mc[1];
  assign bus.input_M_C21 = mc[2]; assign bus.input_M_C22 = mc[3];

  int n_chk = 0;
  int n_fail = 0;
  bit m_last;   // reference model: requester served last

  typedef struct {
    bit          rq0, rq1, ak0, ak1, abk, mst;
    logic [31:0] mc;
    logic [7:0]  exp;    // {g0,g1,start,stable,busy,done0,done1,c_ack}
    logic [31:0] exp_c;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outv();
    return {bus.output_Grant0, bus.output_Grant1, bus.output_M_Start, bus.output_M_Stable,
            bus.output_Busy, bus.output_Done0, bus.output_Done1, bus.output_M_C_Ack};
  endfunction

  function automatic logic [31:0] get_ma(input int i);
    case (i)
      0: return bus.output_M_A11;
      1: return bus.output_M_A12;
      2: return bus.output_M_A21;
      default: return bus.output_M_A22;
    endcase
  endfunction

  function automatic logic [31:0] get_mb(input int i);
    case (i)
      0: return bus.output_M_B11;
      1: return bus.output_M_B12;
      2: return bus.output_M_B21;
      default: return bus.output_M_B22;
    endcase
  endfunction

  function automatic logic [31:0] get_c(input int i);
    case (i)
      0: return bus.output_C11;
      1: return bus.output_C12;
      2: return bus.output_C21;
      default: return bus.output_C22;
    endcase
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {24'd0, outv()}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk({nm, "_ma"}, get_ma(i), 32'd0);
      chk({nm, "_mb"}, get_mb(i), 32'd0);
      chk({nm, "_c"}, get_c(i), 32'd0);
    end
  endtask

  task automatic do_reset();
    rq0 = 0; rq1 = 0; ak0 = 0; ak1 = 0; abk = 0; mst = 0;
    rst_n = 1'b0;
    step();
    chk_all_zero("reset");
    #2 rst_n = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 4; i++) begin
      r0a[i] = $urandom; r0b[i] = $urandom; r1a[i] = $urandom; r1b[i] = $urandom;
    end
  endtask

  // One complete transaction starting in IDLE with rq0/rq1 already driven.
  task automatic txn(input bit drop, input int wi, input int wr, input int wh);
    bit id;
    int gcnt;
    logic [31:0] ea[4], eb[4], ec[4];
    id = (rq0 && rq1) ? !m_last : rq1;
    for (int i = 0; i < 4; i++) begin
      ea[i] = id ? r1a[i] : r0a[i];
      eb[i] = id ? r1b[i] : r0b[i];
    end
    gcnt = 0;
    step();
    chk("grant0", {31'd0, bus.output_Grant0}, {31'd0, !id});
    chk("grant1", {31'd0, bus.output_Grant1}, {31'd0, id});
    chk("start_at_grant", {31'd0, bus.output_M_Start}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("m_a_capture", get_ma(i), ea[i]);
      chk("m_b_capture", get_mb(i), eb[i]);
    end
    if (drop) begin rq0 = 0; rq1 = 0; end
    rand_ops();
    for (int k = 0; k < wi; k++) begin
      step();
      gcnt += int'(bus.output_Grant0) + int'(bus.output_Grant1);
      chk("start_hold", {31'd0, bus.output_M_Start}, 32'd1);
    end
    abk = 1; step(); abk = 0;
    gcnt += int'(bus.output_Grant0) + int'(bus.output_Grant1);
    chk("start_drop", {31'd0, bus.output_M_Start}, 32'd0);
    chk("stable_wait", {31'd0, bus.output_M_Stable}, 32'd1);
    for (int k = 0; k < wr; k++) begin
      ak0 = 1'($urandom_range(0, 1)); ak1 = 1'($urandom_range(0, 1));
      step();
      chk("wait_no_done", {30'd0, bus.output_Done0, bus.output_Done1}, 32'd0);
      chk("wait_busy", {31'd0, bus.output_Busy}, 32'd1);
    end
    ak0 = 0; ak1 = 0;
    for (int i = 0; i < 4; i++) begin mc[i] = $urandom; ec[i] = mc[i]; end
    mst = 1; step();
    chk("done_owner", {30'd0, bus.output_Done0, bus.output_Done1}, id ? 32'd1 : 32'd2);
    chk("c_ack_pulse", {31'd0, bus.output_M_C_Ack}, 32'd1);
    for (int i = 0; i < 4; i++) chk("c_latch", get_c(i), ec[i]);
    for (int i = 0; i < 4; i++) mc[i] = $urandom;
    if (id) ak1 = 1; else ak0 = 1;
    for (int k = 0; k < wh; k++) begin
      if (id) ak0 = 1'($urandom_range(0, 1)); else ak1 = 1'($urandom_range(0, 1));
      step();
      gcnt += int'(bus.output_Grant0) + int'(bus.output_Grant1);
      chk("deliver_hold", {30'd0, bus.output_Done0, bus.output_Done1}, id ? 32'd1 : 32'd2);
      chk("no_restart", {31'd0, bus.output_M_Start | bus.output_M_C_Ack}, 32'd0);
      for (int i = 0; i < 4; i++) chk("c_hold", get_c(i), ec[i]);
    end
    mst = 0; step();
    gcnt += int'(bus.output_Grant0) + int'(bus.output_Grant1);
    chk("exit_idle", {29'd0, bus.output_Busy, bus.output_Done0, bus.output_Done1}, 32'd0);
    ak0 = 0; ak1 = 0;
    for (int i = 0; i < 4; i++) chk("m_a_stable", get_ma(i), ea[i]);
    chk("grant_once", 32'(gcnt), 32'd0);
    m_last = id;
  endtask

  vec_t tbl[10];

  initial begin
    int p;
    tbl[0] = '{1,0,0,0,0,0, 32'h0,        8'b1011_1000, 32'h0};
    tbl[1] = '{0,1,0,0,0,0, 32'h0,        8'b0011_1000, 32'h0};
    tbl[2] = '{0,1,0,0,1,0, 32'h0,        8'b0001_1000, 32'h0};
    tbl[3] = '{0,1,0,0,0,0, 32'h0,        8'b0001_1000, 32'h0};
    tbl[4] = '{0,1,0,0,0,1, 32'h40000000, 8'b0000_1101, 32'h40000000};
    tbl[5] = '{0,1,1,0,0,1, 32'hDEADBEEF, 8'b0000_1100, 32'h40000000};
    tbl[6] = '{0,1,1,0,0,1, 32'hDEADBEEF, 8'b0000_1100, 32'h40000000};
    tbl[7] = '{0,1,0,1,0,0, 32'hDEADBEEF, 8'b0000_1100, 32'h40000000};
    tbl[8] = '{0,1,1,0,0,0, 32'hDEADBEEF, 8'b0000_0000, 32'h40000000};
    tbl[9] = '{0,0,0,0,0,0, 32'h0,        8'b0000_0000, 32'h40000000};

    for (int i = 0; i < 4; i++) mc[i] = 32'h0;
    rand_ops();
    r0a[0] = 32'h3F800000; r0a[1] = 32'h0; r0a[2] = 32'h0; r0a[3] = 32'h3F800000;
    for (int i = 0; i < 4; i++) r0b[i] = 32'h40000000;
    do_reset();

    // Directed single transaction: identity x B, plus stuck M_Stable and foreign Ack
    for (int r = 0; r < 10; r++) begin
      rq0 = tbl[r].rq0; rq1 = tbl[r].rq1; ak0 = tbl[r].ak0; ak1 = tbl[r].ak1;
      abk = tbl[r].abk; mst = tbl[r].mst;
      for (int i = 0; i < 4; i++) mc[i] = tbl[r].mc;
      step();
      chk($sformatf("vec%0d_ctl", r), {24'd0, outv()}, {24'd0, tbl[r].exp});
      for (int i = 0; i < 4; i++) chk($sformatf("vec%0d_c", r), get_c(i), tbl[r].exp_c);
      if (r == 0) begin
        chk("ident_a11", get_ma(0), 32'h3F800000);
        chk("ident_a12", get_ma(1), 32'h0);
        chk("ident_a22", get_ma(3), 32'h3F800000);
        chk("ident_b21", get_mb(2), 32'h40000000);
      end
    end
    m_last = 1'b0;

    // Request pulse that disappears before any edge samples it
    #1 rq0 = 1; #3 rq0 = 0;
    step();
    chk("glitch_req_busy", {31'd0, bus.output_Busy}, 32'd0);
    chk("glitch_req_grant", {31'd0, bus.output_Grant0}, 32'd0);

    // Both requests held from reset: alternating service
    do_reset();
    rq0 = 1; rq1 = 1;
    for (int k = 0; k < 4; k++) txn(1'b0, k % 2, 1, 1);
    rq0 = 0; rq1 = 0;

    // Randomized request patterns and multiplier latencies
    for (int t = 0; t < 24; t++) begin
      rand_ops();
      p = int'($urandom_range(1, 3));
      rq0 = p[0]; rq1 = p[1];
      txn(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in WAIT_RES
    rq0 = 1; step(); rq0 = 0;
    abk = 1; step(); abk = 0;
    chk("pre_reset_wait", {31'd0, bus.output_M_Stable}, 32'd1);
    for (int i = 0; i < 4; i++) mc[i] = $urandom | 32'h1;
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    mst = 1;
    step(); step();
    #2 rst_n = 1'b1;
    m_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_reset_no_done", {29'd0, bus.output_Busy, bus.output_Done0, bus.output_Done1}, 32'd0);
      chk("post_reset_c", get_c(0), 32'd0);
    end
    mst = 0;

`ifdef AXA_ARB_TIMEOUT_EN
    begin
      int n;
      do_reset();
      rq0 = 1; rq1 = 1;
      step();
      chk("to_grant0", {31'd0, bus.output_Grant0}, 32'd1);
      abk = 1; n = 0;
      while (n < 300 && bus.output_Error !== 1'b1) begin
        step(); abk = 0; n++;
      end
      chk("to_latency", 32'(n), 32'd256);
      chk("to_idle", {29'd0, bus.output_Busy, bus.output_Done0, bus.output_Done1}, 32'd0);
      step();
      chk("to_error_pulse", {31'd0, bus.output_Error}, 32'd0);
      chk("to_next_grant1", {31'd0, bus.output_Grant1}, 32'd1);
      do_reset();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axa_mult_arbiter.md
AXA_MULT_ARBITER -- requirements
Module: axa_mult_arbiter

Interface
REQ-001 SHALL have input_Clk, in, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have input_Reset, in, 1: asynchronous, active-low reset.
REQ-003 SHALL have input_Req0 and input_Req1, in, 1 each: requester 0/1 requests a 2x2 product.
REQ-004 SHALL have input_R0_A11..A22 and input_R0_B11..B22, in, 32 each: requester-0 operands (IEEE-754 single).
REQ-005 SHALL have input_R1_A11..A22 and input_R1_B11..B22, in, 32 each: requester-1 operands.
REQ-006 SHALL have input_Ack0 and input_Ack1, in, 1 each: requester has consumed its result.
REQ-007 SHALL have output_Grant0 and output_Grant1, out, 1 each: one-cycle pulse, operands captured.
REQ-008 SHALL have output_Done0 and output_Done1, out, 1 each: result valid for that requester.
REQ-009 SHALL have output_C11..C22, out, 32 each: shared registered result bus.
REQ-010 SHALL have output_Busy, out, 1: high in every state except IDLE.
REQ-011 SHALL have output_M_Start, output_M_Stable and output_M_C_Ack, out, 1 each: multiplier control.
REQ-012 SHALL have output_M_A11..A22 and output_M_B11..B22, out, 32 each: registered multiplier operands.
REQ-013 SHALL have input_M_AB_Ack, input_M_Stable, in, 1 each; input_M_C11..C22, in, 32 each: multiplier status and result.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_RES, DELIVER.
REQ-015 In IDLE with any Req high at an edge, SHALL select a requester, latch its 8 operands into output_M_*, pulse its Grant for one cycle, and enter ISSUE on that edge.
REQ-016 Selection SHALL be round-robin: if both Req are high, grant the requester not served last; if one is high, grant it.
REQ-017 The last-served pointer SHALL update when leaving DELIVER.
REQ-018 In ISSUE, SHALL hold output_M_Start=1 and output_M_Stable=1; on input_M_AB_Ack=1, SHALL drop M_Start and enter WAIT_RES.
REQ-019 output_M_Stable SHALL stay 1 from ISSUE through WAIT_RES; operands SHALL not change until the next grant.
REQ-020 In WAIT_RES with input_M_Stable=1, SHALL latch input_M_C* into output_C*, pulse output_M_C_Ack for one cycle, and enter DELIVER.
REQ-021 In DELIVER, SHALL hold Done of the granted requester high and output_C* constant.
REQ-022 SHALL leave DELIVER for IDLE only when that requester's Ack=1 and input_M_Stable=0 in the same cycle.
REQ-023 Ack or Req from the non-granted requester SHALL be ignored in every non-IDLE state.
REQ-024 A Req dropped before IDLE samples it SHALL not be granted.
REQ-025 Request-to-M_Start latency SHALL be 1 edge; M_Stable-to-Done latency SHALL be 1 edge.
REQ-026 No arithmetic SHALL be applied to data; widths SHALL pass unchanged at 32 bits.

Reset
REQ-027 While input_Reset=0, SHALL force the FSM to IDLE, the pointer to "requester 1 last", and all outputs, including data buses, to 0, regardless of operation in flight.
REQ-028 Operation SHALL resume from IDLE on the first edge after input_Reset returns to 1; no result from an aborted operation SHALL be delivered.

Configuration
REQ-029 With AXA_ARB_TIMEOUT_EN defined, SHALL add output_Error, out, 1, and an 8-bit watchdog counter.
REQ-030 The watchdog SHALL clear on entry to ISSUE and increment each cycle in ISSUE or WAIT_RES.
REQ-031 At count 255, SHALL abort to IDLE, pulse output_Error for one cycle, assert no Done, and update the pointer.
REQ-032 Without AXA_ARB_TIMEOUT_EN, output_Error and the watchdog SHALL not exist, and the arbiter SHALL wait indefinitely.

Verification
REQ-033 Req0=1, A=identity (0x3F800000 on diagonal, 0 elsewhere), B11..B22=0x40000000, model returns C=B -> Grant0 pulse, M_Start next cycle, Done0 with C11..C22=0x40000000, exits on Ack0.
REQ-034 Req0=Req1=1 held after reset -> grant order R0, R1, R0, R1; each Grant pulses exactly once per transaction.
REQ-035 Model holds M_Stable=1 three cycles after Ack0 -> remains in DELIVER until M_Stable=0; no second M_Start.
REQ-036 input_Reset=0 during WAIT_RES -> all outputs 0 immediately (asynchronous), IDLE, no Done after release.
REQ-037 With AXA_ARB_TIMEOUT_EN, model never asserts M_Stable -> output_Error pulses 256 cycles after ISSUE entry, Busy=0, then R1 is granted next.
REQ-038 Ack1 pulsed while R0 in DELIVER -> ignored; Done0 stays 1.
